// File: rtl/drum_pad_conditioner.sv
// Four-channel drum pad front end: sync, debounce, fixed-length hold and lockout
// per pad, plus hit strobes, last-hit index and a saturating hit counter.
module drum_pad_conditioner #(
  parameter int DEB_CYCLES     = 250000,
  parameter int HOLD_CYCLES    = 2500000,
  parameter int LOCKOUT_CYCLES = 1250000,
  parameter int CW             = 24
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic [3:0] pad_raw,
  input  logic       enable,
  output logic [3:0] drum,
  output logic [3:0] hit_pulse,
  output logic [1:0] last_hit,
  output logic [7:0] hit_count
);

  typedef enum logic [1:0] {IDLE, DEB, HIT, LOCK} state_t;

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCKOUT_CYCLES - 1);

  logic [3:0] s1;
  logic [3:0] s2;
  logic [3:0] in_hit;
  logic [3:0] first_hit;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pad_raw;
      s2 <= s1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_chan
    state_t        state;
    state_t        state_next;
    logic [CW-1:0] timer;
    logic [CW-1:0] timer_next;

    always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
        state <= IDLE;
        timer <= '0;
      end else begin
        state <= state_next;
        timer <= timer_next;
      end
    end

    // LOCK only leaves once the timer has saturated and the pad is released,
    // so a pad held down never re-fires.
    always_comb begin
      state_next = state;
      timer_next = timer;
      if (!enable) begin
        state_next = IDLE;
        timer_next = '0;
      end else begin
        case (state)
          IDLE: begin
            if (s2[g]) begin
              state_next = DEB;
              timer_next = '0;
            end
          end
          DEB: begin
            if (!s2[g]) begin
              state_next = IDLE;
              timer_next = '0;
            end else if (timer == DEB_LAST) begin
              state_next = HIT;
              timer_next = '0;
            end else begin
              timer_next = timer + 1'b1;
            end
          end
          HIT: begin
            if (timer == HOLD_LAST) begin
              state_next = LOCK;
              timer_next = '0;
            end else begin
              timer_next = timer + 1'b1;
            end
          end
          LOCK: begin
            if (timer == LOCK_LAST) begin
              if (!s2[g]) begin
                state_next = IDLE;
                timer_next = '0;
              end
            end else begin
              timer_next = timer + 1'b1;
            end
          end
          default: begin
            state_next = IDLE;
            timer_next = '0;
          end
        endcase
      end
    end

    assign in_hit[g]    = (state == HIT);
    assign first_hit[g] = (state == HIT) && (timer == '0);
  end

  logic [8:0] count_sum;
  assign count_sum = {1'b0, hit_count} + 9'(hit_pulse[0]) + 9'(hit_pulse[1])
                   + 9'(hit_pulse[2]) + 9'(hit_pulse[3]);

  // Outputs are registered one cycle behind the channel FSMs; enable gates them
  // so a disabled edge clears drum and strobes at once.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      drum      <= '0;
      hit_pulse <= '0;
      last_hit  <= '0;
      hit_count <= '0;
    end else begin
      drum      <= enable ? in_hit : 4'b0000;
      hit_pulse <= enable ? first_hit : 4'b0000;
      if (hit_pulse[0])      last_hit <= 2'd0;
      else if (hit_pulse[1]) last_hit <= 2'd1;
      else if (hit_pulse[2]) last_hit <= 2'd2;
      else if (hit_pulse[3]) last_hit <= 2'd3;
      hit_count <= (count_sum > 9'd255) ? 8'd255 : count_sum[7:0];
    end
  end

endmodule

// File: tb/tb_drum_pad_conditioner.sv
// Randomized and scenario bench for drum_pad_conditioner, checked every cycle
// against an edge-counting reference model of the pad rules.
module tb_drum_pad_conditioner;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int LOCK = 6;

  logic       sysclk;
  logic       rst_n;
  logic [3:0] pad_raw;
  logic       enable;
  logic [3:0] drum;
  logic [3:0] hit_pulse;
  logic [1:0] last_hit;
  logic [7:0] hit_count;

  drum_pad_conditioner #(
    .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .LOCKOUT_CYCLES(LOCK), .CW(8)
  ) dut (
    .sysclk(sysclk), .rst_n(rst_n), .pad_raw(pad_raw), .enable(enable),
    .drum(drum), .hit_pulse(hit_pulse), .last_hit(last_hit), .hit_count(hit_count)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int vectors = 0;
  int miscompares = 0;

  // Reference: per pad a mode (0 armed, 1 sounding, 2 locked out), a run of
  // consecutive high levels, and an in-mode cycle count.
  int   mode [4];
  int   run  [4];
  int   cnt  [4];
  bit   s1m  [4];
  bit   s2m  [4];
  logic [3:0] exp_drum;
  logic [3:0] exp_pulse;
  logic [1:0] exp_last;
  int   exp_count;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mode[i] = 0; run[i] = 0; cnt[i] = 0; s1m[i] = 0; s2m[i] = 0;
    end
    exp_drum = '0; exp_pulse = '0; exp_last = '0; exp_count = 0;
  endtask

  task automatic model_edge(input logic [3:0] pad, input logic en);
    logic [3:0] nd;
    logic [3:0] np;
    if (exp_pulse != 0) begin
      for (int i = 3; i >= 0; i--) if (exp_pulse[i]) exp_last = 2'(i);
      exp_count = exp_count + $countones(exp_pulse);
      if (exp_count > 255) exp_count = 255;
    end
    for (int i = 0; i < 4; i++) begin
      nd[i] = en && (mode[i] == 1);
      np[i] = en && (mode[i] == 1) && (cnt[i] == 0);
      if (!en) begin
        mode[i] = 0; run[i] = 0;
      end else if (mode[i] == 0) begin
        run[i] = s2m[i] ? run[i] + 1 : 0;
        if (run[i] == DEB + 1) begin mode[i] = 1; cnt[i] = 0; end
      end else if (mode[i] == 1) begin
        if (cnt[i] == HOLD - 1) begin mode[i] = 2; cnt[i] = 0; end
        else cnt[i]++;
      end else begin
        if (cnt[i] >= LOCK - 1 && !s2m[i]) begin mode[i] = 0; run[i] = 0; end
        else if (cnt[i] < LOCK - 1) cnt[i]++;
      end
      s2m[i] = s1m[i];
      s1m[i] = pad[i];
    end
    exp_drum = nd;
    exp_pulse = np;
  endtask

  task automatic applyStimulus(input logic [3:0] pad, input logic en);
    pad_raw = pad;
    enable  = en;
    @(posedge sysclk);
    model_edge(pad, en);
    #1;
    checkOutput("drum", 32'(drum), 32'(exp_drum));
    checkOutput("hit_pulse", 32'(hit_pulse), 32'(exp_pulse));
    checkOutput("last_hit", 32'(last_hit), 32'(exp_last));
    checkOutput("hit_count", 32'(hit_count), 32'(exp_count));
  endtask

  task automatic hold_pad(input logic [3:0] pad, input logic en, input int n);
    for (int k = 0; k < n; k++) applyStimulus(pad, en);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_drum", 32'(drum), 0);
    checkOutput("rst_pulse", 32'(hit_pulse), 0);
    checkOutput("rst_last", 32'(last_hit), 0);
    checkOutput("rst_count", 32'(hit_count), 0);
    model_reset();
    @(posedge sysclk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int base;
    pad_raw = '0;
    enable  = 1'b1;
    rst_n   = 1'b0;
    #3;
    do_reset();

    // Clean hit on pad 0
    for (int k = 0; k < 30; k++) begin
      applyStimulus(4'b0001, 1'b1);
      if (k == 7) checkOutput("t1_pulse_edge7", 32'(hit_pulse), 1);
      if (k == 6) checkOutput("t1_pulse_edge6", 32'(hit_pulse), 0);
    end
    checkOutput("t1_count", 32'(hit_count), 1);
    hold_pad(4'b0000, 1'b1, 10);

    // Bounce on pad 1
    for (int k = 0; k < 20; k++) applyStimulus(((k / 2) % 2) != 0 ? 4'b0010 : 4'b0000, 1'b1);
    hold_pad(4'b0000, 1'b1, 10);
    checkOutput("t2_count", 32'(hit_count), 1);

    // Simultaneous pads 2 and 3
    hold_pad(4'b1100, 1'b1, 20);
    checkOutput("t3_last", 32'(last_hit), 2);
    checkOutput("t3_count", 32'(hit_count), 3);
    hold_pad(4'b0000, 1'b1, 12);

    // Re-arm: gap during hold ignored, release in lockout, early re-press
    hold_pad(4'b0001, 1'b1, 10);
    hold_pad(4'b0000, 1'b1, 2);
    hold_pad(4'b0001, 1'b1, 4);
    hold_pad(4'b0000, 1'b1, 12);
    hold_pad(4'b0001, 1'b1, 16);
    hold_pad(4'b0000, 1'b1, 1);
    hold_pad(4'b0001, 1'b1, 20);
    checkOutput("t4_count", 32'(hit_count), 5);
    hold_pad(4'b0000, 1'b1, 10);
    hold_pad(4'b0001, 1'b1, 14);
    hold_pad(4'b0000, 1'b1, 12);
    checkOutput("t4_rearm_count", 32'(hit_count), 6);

    // Enable dropped mid-hold
    hold_pad(4'b0001, 1'b1, 10);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("t5_drum_cut", 32'(drum), 0);
    hold_pad(4'b0001, 1'b0, 2);
    checkOutput("t5_count", 32'(hit_count), 7);
    hold_pad(4'b0001, 1'b1, 16);
    checkOutput("t5_rehit", 32'(hit_count), 8);
    hold_pad(4'b0000, 1'b1, 12);

    // Random pad activity with occasional enable drops
    for (int k = 0; k < 60; k++)
      hold_pad(4'($urandom_range(0, 15)), ($urandom_range(0, 15) != 0),
               int'($urandom_range(1, 18)));
    hold_pad(4'b0000, 1'b1, 30);

    // Saturation
    base = exp_count;
    for (int r = 0; r < 70; r++) begin
      hold_pad(4'b1111, 1'b1, 16);
      hold_pad(4'b0000, 1'b1, 10);
    end
    checkOutput("t6_sat", 32'(hit_count), 255);
    checkOutput("t6_base", 32'(base <= 255), 1);
    checkOutput("t6_last", 32'(last_hit), 0);

    // Reset in the middle of a hold
    hold_pad(4'b0001, 1'b1, 10);
    checkOutput("t6_drum_before_rst", 32'(drum), 1);
    do_reset();
    hold_pad(4'b0000, 1'b1, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
